dmem_bridge: RTL and testbench

DMEM_BRIDGE -- requirements
Module: dmem_bridge

---
 rtl/mem_bus_pkg.sv | 22 ++
 rtl/dmem_bridge_if.sv | 35 +++
 rtl/cycle_timer.sv | 41 ++++
 rtl/dmem_bridge.sv | 132 +++++++++++++
 tb/tb_dmem_bridge.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the core data-memory bridge.
// No logic; state encoding, default timeout and error read data.
// Imported by the bridge and its wait-counter sub-module.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;
    localparam int unsigned TIMER_W                = 8;
    localparam logic [31:0] ERR_RDATA              = 32'h0;

    // Core accesses are word-sized; anything not on a 4-byte boundary is rejected.
    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// Core-side and backing-memory-side signals of the data-memory bridge.
// Pure wiring, no latency.
// Core is held off via stall_o; the memory side completes via bus_ack_i.
interface dmem_bridge_if;
    logic        mem_req_i;
    logic        enable_wmem_i;
    logic [31:0] alu_addr_i32;
    logic [31:0] write_data_i32;
    logic [31:0] read_data_o32;
    logic        stall_o;
    logic        done_o;
    logic        err_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o32;
    logic [31:0] bus_wdata_o32;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i32;

    // Bridge view
    modport slave (
        input  mem_req_i, enable_wmem_i, alu_addr_i32, write_data_i32,
        input  bus_ack_i, bus_rdata_i32,
        output read_data_o32, stall_o, done_o, err_o,
        output bus_req_o, bus_we_o, bus_addr_o32, bus_wdata_o32
    );

    // Core plus backing-memory view
    modport master (
        output mem_req_i, enable_wmem_i, alu_addr_i32, write_data_i32,
        output bus_ack_i, bus_rdata_i32,
        input  read_data_o32, stall_o, done_o, err_o,
        input  bus_req_o, bus_we_o, bus_addr_o32, bus_wdata_o32
    );
endinterface

// File: rtl/cycle_timer.sv
// Bus wait counter with synchronous clear and terminal-count flag at LIMIT-1.
// tc_o is combinational from the count register; count updates one cycle after en_i.
// Saturates at the terminal count; clear has priority over enable.
module cycle_timer
    import mem_bus_pkg::*;
#(
    parameter int unsigned LIMIT = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned W     = TIMER_W
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tc_o = (cnt_q == W'(LIMIT - 1));

    // Next count: clear, else step while enabled and not yet terminal
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_bridge.sv
// Bridges the core data-memory port to a req/ack backing memory with timeout abort.
// Latency: ack at cycle k after the request gives done_o at cycle k+1; misaligned errors at cycle 1.
// Core is stalled while a request waits in IDLE or the bus is busy; bus_req_o holds until ack or timeout.
module dmem_bridge
    import mem_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic          clk_i,
    input  logic          reset_i,
    dmem_bridge_if.slave  dm
);

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        timer_tc;

    // Counter runs only in BUS and restarts from zero on every entry
    cycle_timer #(
        .LIMIT (TIMEOUT_CYCLES),
        .W     (TIMER_W)
    ) u_timer (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (state_q != ST_BUS),
        .en_i    ((state_q == ST_BUS) && !dm.bus_ack_i),
        .tc_o    (timer_tc)
    );

    // State register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; an ack on the terminal cycle beats the timeout
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (dm.mem_req_i) begin
                state_d = is_word_aligned(dm.alu_addr_i32) ? ST_BUS : ST_ERR;
            end
            ST_BUS: begin
                if (dm.bus_ack_i) begin
                    state_d = ST_RESP;
                end else if (timer_tc) begin
                    state_d = ST_ERR;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; stall never looks at bus_ack_i
    always_comb begin
        dm.stall_o   = 1'b0;
        dm.done_o    = 1'b0;
        dm.err_o     = 1'b0;
        dm.bus_req_o = 1'b0;
        unique case (state_q)
            ST_IDLE: dm.stall_o = dm.mem_req_i;
            ST_BUS: begin
                dm.stall_o   = 1'b1;
                dm.bus_req_o = 1'b1;
            end
            ST_RESP: dm.done_o = 1'b1;
            ST_ERR: begin
                dm.done_o = 1'b1;
                dm.err_o  = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath next values: capture on accept, load data on ack, zero on aborted loads
    always_comb begin
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            ST_IDLE: if (dm.mem_req_i) begin
                if (is_word_aligned(dm.alu_addr_i32)) begin
                    we_d    = dm.enable_wmem_i;
                    addr_d  = {dm.alu_addr_i32[31:2], 2'b00};
                    wdata_d = dm.write_data_i32;
                end else if (!dm.enable_wmem_i) begin
                    rdata_d = ERR_RDATA;
                end
            end
            ST_BUS: begin
                if (dm.bus_ack_i) begin
                    if (!we_q) begin
                        rdata_d = dm.bus_rdata_i32;
                    end
                end else if (timer_tc && !we_q) begin
                    rdata_d = ERR_RDATA;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign dm.bus_we_o      = we_q;
    assign dm.bus_addr_o32  = addr_q;
    assign dm.bus_wdata_o32 = wdata_q;
    assign dm.read_data_o32 = rdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Testbench for dmem_bridge: two instances (timeout 16 and timeout 4) sharing one stimulus source.
// Only the selected instance ever sees mem_req_i; the other stays idle and ignores the bus.
// Transaction-level reference model predicts done cycle, error, bus occupancy and read data.
module tb_dmem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        req, we, ack;
    logic [31:0] addr, wdata, rdata;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    logic [31:0] rd_model [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_bridge_if if16();
    dmem_bridge_if if4();

    assign if16.mem_req_i      = req & ~sel;
    assign if4.mem_req_i       = req & sel;
    assign if16.enable_wmem_i  = we;
    assign if4.enable_wmem_i   = we;
    assign if16.alu_addr_i32   = addr;
    assign if4.alu_addr_i32    = addr;
    assign if16.write_data_i32 = wdata;
    assign if4.write_data_i32  = wdata;
    assign if16.bus_ack_i      = ack;
    assign if4.bus_ack_i       = ack;
    assign if16.bus_rdata_i32  = rdata;
    assign if4.bus_rdata_i32   = rdata;

    dmem_bridge #(.TIMEOUT_CYCLES(16)) dut16 (.clk_i(clk), .reset_i(rst), .dm(if16));
    dmem_bridge #(.TIMEOUT_CYCLES(4))  dut4  (.clk_i(clk), .reset_i(rst), .dm(if4));

    logic        o_stall, o_done, o_err, o_breq, o_bwe;
    logic [31:0] o_baddr, o_bwdata, o_rd;
    assign o_stall  = sel ? if4.stall_o       : if16.stall_o;
    assign o_done   = sel ? if4.done_o        : if16.done_o;
    assign o_err    = sel ? if4.err_o         : if16.err_o;
    assign o_breq   = sel ? if4.bus_req_o     : if16.bus_req_o;
    assign o_bwe    = sel ? if4.bus_we_o      : if16.bus_we_o;
    assign o_baddr  = sel ? if4.bus_addr_o32  : if16.bus_addr_o32;
    assign o_bwdata = sel ? if4.bus_wdata_o32 : if16.bus_wdata_o32;
    assign o_rd     = sel ? if4.read_data_o32 : if16.read_data_o32;

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic        w;
        logic [31:0] d;
        int          k;
        logic [31:0] rdv;
        int          e_done;
        logic        e_err;
        int          e_breq;
        logic [31:0] e_rd;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One core access; ack pulses in cycle k (k=0: never). Returns what was observed.
    task automatic run_txn(input logic s, input logic [31:0] a, input logic w, input logic [31:0] d,
                           input int k, input logic [31:0] rdv,
                           output int done_c, output logic err_seen, output int breq_n,
                           output int stall_n, output logic bus_ok, output logic [31:0] rd_seen,
                           output int done_abs);
        done_c = -1; err_seen = 1'b0; breq_n = 0; stall_n = 0; bus_ok = 1'b1;
        rd_seen = '0; done_abs = -1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            sel = s; req = 1'b1; we = w; addr = a; wdata = d;
            ack   = (c >= 1) && (c == k);
            rdata = (c == k) ? rdv : $urandom();
            #1;
            if (c == 0) chk("idle_no_pulse", {30'd0, o_done, o_err}, 32'd0);
            if (o_stall) stall_n++;
            if (o_breq) begin
                breq_n++;
                if (o_bwe !== w || o_baddr !== a || o_bwdata !== d) bus_ok = 1'b0;
            end
            if (o_done) begin
                done_c = c; err_seen = o_err; rd_seen = o_rd; done_abs = cyc;
                break;
            end
        end
        req = 1'b0; ack = 1'b0;
        if (done_c < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL txn_timeout: no done_o within 300 cycles, expected done_o");
        end
    endtask

    task automatic check_txn(input string tag, input int done_c, input logic err_seen,
                             input int breq_n, input int stall_n, input logic bus_ok,
                             input logic [31:0] rd_seen, input int e_done, input logic e_err,
                             input int e_breq, input logic [31:0] e_rd);
        chk({tag, ".done_cycle"}, 32'(done_c),  32'(e_done));
        chk({tag, ".err"},        32'(err_seen), 32'(e_err));
        chk({tag, ".breq_cycles"},32'(breq_n),  32'(e_breq));
        chk({tag, ".stall_cycles"},32'(stall_n), 32'(e_done));
        chk({tag, ".bus_fields"}, 32'(bus_ok),  32'd1);
        chk({tag, ".read_data"},  rd_seen,      e_rd);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          dc, bn, sn, da, pa;
        logic        es, bo;
        logic [31:0] rs, a, d, rdv, e_rd;
        logic        s, w;
        int          k, tmo, e_done, e_breq, seen;
        logic        e_err;

        // Hand-derived vectors (cycle 0 = request cycle in IDLE)
        tbl[0]  = '{1'b0, 32'h0000_0040, 1'b0, 32'h0,         5,  32'h1234_5678, 6,  1'b0, 5,  32'h1234_5678};
        tbl[1]  = '{1'b0, 32'h0000_0040, 1'b1, 32'hCAFE_F00D, 2,  32'hDEAD_DEAD, 3,  1'b0, 2,  32'h1234_5678};
        tbl[2]  = '{1'b0, 32'h0000_0042, 1'b0, 32'h0,         0,  32'h0,         1,  1'b1, 0,  32'h0};
        tbl[3]  = '{1'b0, 32'h0000_0100, 1'b0, 32'h0,         1,  32'hAAAA_5555, 2,  1'b0, 1,  32'hAAAA_5555};
        tbl[4]  = '{1'b0, 32'h0000_0101, 1'b1, 32'h1111_1111, 0,  32'h0,         1,  1'b1, 0,  32'hAAAA_5555};
        tbl[5]  = '{1'b1, 32'h0000_0080, 1'b0, 32'h0,         4,  32'h0BAD_BEEF, 5,  1'b0, 4,  32'h0BAD_BEEF};
        tbl[6]  = '{1'b1, 32'h0000_0084, 1'b0, 32'h0,         0,  32'h0,         5,  1'b1, 4,  32'h0};
        tbl[7]  = '{1'b1, 32'h0000_0088, 1'b0, 32'h0,         3,  32'h5A5A_5A5A, 4,  1'b0, 3,  32'h5A5A_5A5A};
        tbl[8]  = '{1'b1, 32'h0000_008C, 1'b1, 32'h7777_7777, 0,  32'h0,         5,  1'b1, 4,  32'h5A5A_5A5A};
        tbl[9]  = '{1'b0, 32'h0000_0010, 1'b0, 32'h0,         16, 32'h0F0F_0F0F, 17, 1'b0, 16, 32'h0F0F_0F0F};
        tbl[10] = '{1'b0, 32'h0000_0014, 1'b0, 32'h0,         17, 32'h3333_3333, 17, 1'b1, 16, 32'h0};

        rst = 1'b1; sel = 1'b0; req = 1'b0; we = 1'b0; ack = 1'b0;
        addr = '0; wdata = '0; rdata = '0;

        // Reset state of both instances
        repeat (2) @(negedge clk);
        #1;
        chk("rst16.outputs", {27'd0, if16.done_o, if16.err_o, if16.bus_req_o, if16.bus_we_o, if16.stall_o}, 32'd0);
        chk("rst16.read_data", if16.read_data_o32, 32'h0);
        chk("rst16.bus_addr",  if16.bus_addr_o32,  32'h0);
        chk("rst16.bus_wdata", if16.bus_wdata_o32, 32'h0);
        chk("rst4.outputs",   {27'd0, if4.done_o, if4.err_o, if4.bus_req_o, if4.bus_we_o, if4.stall_o}, 32'd0);
        chk("rst4.read_data", if4.read_data_o32, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst.outputs", {29'd0, o_done, o_err, o_breq}, 32'd0);
        chk("post_rst.stall",   32'(o_stall), 32'd0);
        rd_model[0] = '0; rd_model[1] = '0;

        // Directed table
        for (int i = 0; i < 11; i++) begin
            run_txn(tbl[i].s, tbl[i].a, tbl[i].w, tbl[i].d, tbl[i].k, tbl[i].rdv,
                    dc, es, bn, sn, bo, rs, da);
            check_txn($sformatf("vec%0d", i), dc, es, bn, sn, bo, rs,
                      tbl[i].e_done, tbl[i].e_err, tbl[i].e_breq, tbl[i].e_rd);
            rd_model[tbl[i].s] = tbl[i].e_rd;
        end

        // Ack while idle must be ignored
        @(negedge clk);
        sel = 1'b0; req = 1'b0; ack = 1'b1; rdata = 32'hFFFF_FFFF;
        #1;
        chk("idle_ack.outputs", {29'd0, o_done, o_err, o_breq}, 32'd0);
        @(negedge clk);
        ack = 1'b0;
        #1;
        chk("idle_ack.done", 32'(o_done), 32'd0);
        chk("idle_ack.read_data", o_rd, rd_model[0]);

        // Three back-to-back loads, ack delay 1
        pa = -1;
        for (int i = 0; i < 3; i++) begin
            rdv = 32'hB000_0000 + 32'(i * 17);
            run_txn(1'b0, 32'h200 + 32'(4 * i), 1'b0, 32'h0, 1, rdv, dc, es, bn, sn, bo, rs, da);
            check_txn($sformatf("b2b%0d", i), dc, es, bn, sn, bo, rs, 2, 1'b0, 1, rdv);
            if (i > 0) chk($sformatf("b2b%0d.spacing", i), 32'(da - pa), 32'd3);
            pa = da;
            rd_model[0] = rdv;
        end

        // Reset in the middle of a bus wait
        @(negedge clk);
        sel = 1'b0; req = 1'b1; we = 1'b0; addr = 32'h300; wdata = 32'h0; ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("midrst.busy_before", 32'(o_breq), 32'd1);
        @(negedge clk);
        req = 1'b0; rst = 1'b1;
        #1;
        chk("midrst.bus_req_drop", 32'(o_breq), 32'd0);
        chk("midrst.regs", {o_baddr[30:0], o_bwe} | o_rd | o_bwdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (o_done || o_err || o_breq) seen++;
        end
        chk("midrst.no_done_after", 32'(seen), 32'd0);
        rd_model[0] = '0; rd_model[1] = '0;
        run_txn(1'b0, 32'h304, 1'b0, 32'h0, 2, 32'h600D_D00D, dc, es, bn, sn, bo, rs, da);
        check_txn("midrst.next", dc, es, bn, sn, bo, rs, 3, 1'b0, 2, 32'h600D_D00D);
        rd_model[0] = 32'h600D_D00D;

        // Randomized accesses against the transaction model
        for (int i = 0; i < 40; i++) begin
            s   = 1'($urandom_range(0, 1));
            w   = 1'($urandom_range(0, 1));
            a   = $urandom();
            a[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            d   = $urandom();
            k   = $urandom_range(0, 20);
            rdv = $urandom();
            tmo = s ? 4 : 16;
            if (a[1:0] != 2'b00) begin
                e_done = 1; e_err = 1'b1; e_breq = 0;
                e_rd = w ? rd_model[s] : 32'h0;
            end else if (k >= 1 && k <= tmo) begin
                e_done = k + 1; e_err = 1'b0; e_breq = k;
                e_rd = w ? rd_model[s] : rdv;
            end else begin
                e_done = tmo + 1; e_err = 1'b1; e_breq = tmo;
                e_rd = w ? rd_model[s] : 32'h0;
            end
            run_txn(s, a, w, d, k, rdv, dc, es, bn, sn, bo, rs, da);
            check_txn($sformatf("rnd%0d", i), dc, es, bn, sn, bo, rs, e_done, e_err, e_breq, e_rd);
            rd_model[s] = e_rd;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
